hold_queue: RTL and testbench

Parametrised successor to the calc1 hold register. Captures a two-cycle request (command plus operand 1, then operand 2 on the following cycle) and assembles it into one entry. Buffers up to DEPTH complete entries in a FIFO. Presents the oldest entry to the priority logic over a valid/ready handshake, so back-pressure no longer loses commands silently.

---
 rtl/hold_queue.sv | 153 +++++++++++++++
 tb/tb_hold_queue.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hold_queue.sv
// hold_queue: assembles two-cycle requests (command + operand 1, then
// operand 2) into single entries and buffers up to DEPTH of them in a FIFO.
// The oldest entry is offered to the consumer over a valid/ready handshake.
// A completed entry that finds the FIFO full (and no pop in the same cycle)
// is discarded and reported on hold_drop.
// Optional feature: define HOLDQ_STATS_EN to get a saturating 8-bit drop
// counter on hold_drop_cnt; without it the port is tied to 0.
module hold_queue #(
  parameter int CW    = 4,
  parameter int DW    = 32,
  parameter int DEPTH = 4,
  parameter int CNTW  = $clog2(DEPTH + 1)
) (
  input  logic            c_clk,
  input  logic            reset,
  input  logic [CW-1:0]   req_cmd_in,
  input  logic [DW-1:0]   req_data_in,
  output logic            hold_valid,
  input  logic            hold_ready,
  output logic [CW-1:0]   hold_prio_req,
  output logic [DW-1:0]   hold_data1,
  output logic [DW-1:0]   hold_data2,
  output logic [CNTW-1:0] hold_count,
  output logic            hold_full,
  output logic            hold_drop,
  output logic [7:0]      hold_drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = CW + 2 * DW;
  localparam logic [CNTW-1:0] DEPTH_C = CNTW'(DEPTH);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OP2  = 1'b1
  } state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   cmd_reg, cmd_next;
  logic [DW-1:0]   op1_reg, op1_next;
  logic            push_try;

  logic [AW-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [CNTW-1:0] count_reg, count_next;
  logic            drop_reg;

  logic [EW-1:0]   mem [DEPTH];
  logic [EW-1:0]   head_word;
  logic            pop, push_ok, drop;

  // Assembly state: command and first operand held while waiting for operand 2.
  always_ff @(posedge c_clk) begin
    if (!reset) begin
      state_reg <= ST_IDLE;
      cmd_reg   <= '0;
      op1_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cmd_reg   <= cmd_next;
      op1_reg   <= op1_next;
    end
  end

  // Next-state logic: a non-zero command opens a request; the following
  // cycle carries operand 2 regardless of what the command bus shows.
  always_comb begin
    state_next = state_reg;
    cmd_next   = cmd_reg;
    op1_next   = op1_reg;
    push_try   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (req_cmd_in != '0) begin
          cmd_next   = req_cmd_in;
          op1_next   = req_data_in;
          state_next = ST_OP2;
        end
      end
      ST_OP2: begin
        push_try   = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // A push may use the slot freed by a same-cycle pop, so a full FIFO
  // being drained never loses an entry.
  always_comb begin
    pop     = (count_reg != '0) && hold_ready;
    push_ok = push_try && ((count_reg < DEPTH_C) || pop);
    drop    = push_try && !push_ok;
  end

  // Entry storage; written only on a successful push, never reset.
  always_ff @(posedge c_clk) begin
    if (reset && push_ok) begin
      mem[wr_ptr_reg] <= {cmd_reg, op1_reg, req_data_in};
    end
  end

  // Occupancy bookkeeping: a simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_next = count_reg;
    case ({push_ok, pop})
      2'b10:   count_next = count_reg + CNTW'(1);
      2'b01:   count_next = count_reg - CNTW'(1);
      default: count_next = count_reg;
    endcase
  end

  // Pointers wrap naturally; full/empty come from the count, not from them.
  always_ff @(posedge c_clk) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      drop_reg   <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)     rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_next;
      drop_reg  <= drop;
    end
  end

`ifdef HOLDQ_STATS_EN
  logic [7:0] drop_cnt_reg;

  // Saturating drop counter, cleared only by reset.
  always_ff @(posedge c_clk) begin
    if (!reset) begin
      drop_cnt_reg <= '0;
    end else if (drop && (drop_cnt_reg != 8'hFF)) begin
      drop_cnt_reg <= drop_cnt_reg + 8'd1;
    end
  end

  assign hold_drop_cnt = drop_cnt_reg;
`else
  assign hold_drop_cnt = 8'h00;
`endif

  // Head is a combinational read at the read pointer, forced to 0 when empty
  // so stale storage contents never leak out.
  assign head_word  = mem[rd_ptr_reg];
  assign hold_valid = (count_reg != '0);
  assign {hold_prio_req, hold_data1, hold_data2} = hold_valid ? head_word : '0;
  assign hold_count = count_reg;
  assign hold_full  = (count_reg == DEPTH_C);
  assign hold_drop  = drop_reg;

endmodule

// File: tb/tb_hold_queue.sv
// Self-checking bench for hold_queue: directed scenarios plus randomized
// traffic compared against a queue-based reference model.
module tb_hold_queue;

  localparam int CW    = 4;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int CNTW  = $clog2(DEPTH + 1);
  localparam int OW    = 1 + CW + 2 * DW + CNTW + 1 + 1 + 8;

`ifdef HOLDQ_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic            c_clk;
  logic            reset;
  logic [CW-1:0]   req_cmd_in;
  logic [DW-1:0]   req_data_in;
  logic            hold_valid;
  logic            hold_ready;
  logic [CW-1:0]   hold_prio_req;
  logic [DW-1:0]   hold_data1;
  logic [DW-1:0]   hold_data2;
  logic [CNTW-1:0] hold_count;
  logic            hold_full;
  logic            hold_drop;
  logic [7:0]      hold_drop_cnt;

  int vectors     = 0;
  int miscompares = 0;

  hold_queue #(.CW(CW), .DW(DW), .DEPTH(DEPTH)) dut (
    .c_clk        (c_clk),
    .reset        (reset),
    .req_cmd_in   (req_cmd_in),
    .req_data_in  (req_data_in),
    .hold_valid   (hold_valid),
    .hold_ready   (hold_ready),
    .hold_prio_req(hold_prio_req),
    .hold_data1   (hold_data1),
    .hold_data2   (hold_data2),
    .hold_count   (hold_count),
    .hold_full    (hold_full),
    .hold_drop    (hold_drop),
    .hold_drop_cnt(hold_drop_cnt)
  );

  initial c_clk = 1'b0;
  always #5 c_clk = ~c_clk;

  logic [OW-1:0] obs;
  assign obs = {hold_valid, hold_prio_req, hold_data1, hold_data2,
                hold_count, hold_full, hold_drop, hold_drop_cnt};

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [CW-1:0] cmd;
    logic [DW-1:0] d1;
    logic [DW-1:0] d2;
  } entry_t;

  entry_t        m_q[$];
  bit            m_pend = 1'b0;
  logic [CW-1:0] m_pcmd = '0;
  logic [DW-1:0] m_pd1  = '0;
  bit            m_drop = 1'b0;
  int            m_dcnt = 0;

  always @(posedge c_clk) begin : model
    bit     pop_now;
    bit     was_full;
    entry_t e;
    if (!reset) begin
      m_q.delete();
      m_pend = 1'b0;
      m_drop = 1'b0;
      m_dcnt = 0;
    end else begin
      pop_now  = (m_q.size() != 0) && hold_ready;
      was_full = (m_q.size() == DEPTH);
      m_drop   = 1'b0;
      if (pop_now) void'(m_q.pop_front());
      if (m_pend) begin
        e.cmd = m_pcmd;
        e.d1  = m_pd1;
        e.d2  = req_data_in;
        if (was_full && !pop_now) begin
          m_drop = 1'b1;
          if (m_dcnt < 255) m_dcnt++;
        end else begin
          m_q.push_back(e);
        end
        m_pend = 1'b0;
      end else if (req_cmd_in != '0) begin
        m_pend = 1'b1;
        m_pcmd = req_cmd_in;
        m_pd1  = req_data_in;
      end
    end
  end

  function automatic logic [OW-1:0] model_out();
    entry_t     h;
    logic [7:0] dc;
    h  = (m_q.size() != 0) ? m_q[0] : '0;
    dc = STATS ? 8'(m_dcnt) : 8'h00;
    return {m_q.size() != 0, h.cmd, h.d1, h.d2, CNTW'(m_q.size()),
            m_q.size() == DEPTH, m_drop, dc};
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(negedge c_clk);
  endtask

  task automatic do_reset();
    reset = 1'b0; req_cmd_in = '0; req_data_in = '0; hold_ready = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  // Drives a full request; returns at the negedge after the operand-2 edge.
  task automatic send_req(input logic [CW-1:0] c, input logic [DW-1:0] a,
                          input logic [DW-1:0] b, input logic rdy_a,
                          input logic rdy_b);
    req_cmd_in = c;  req_data_in = a; hold_ready = rdy_a;
    tick();
    req_cmd_in = '0; req_data_in = b; hold_ready = rdy_b;
    tick();
    req_data_in = '0; hold_ready = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b0; req_cmd_in = 4'hF; req_data_in = 32'hFFFF_FFFF; hold_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      vectors++;
      if (obs !== '0) begin
        miscompares++;
        $display("FAIL reset_outputs: got %h expected 0", obs);
      end
    end
    reset = 1'b1; req_cmd_in = '0; req_data_in = '0; hold_ready = 1'b0;
    tick();
    vectors++;
    if (obs !== '0) begin
      miscompares++;
      $display("FAIL idle_after_reset: got %h expected 0", obs);
    end
    $display("test_reset done");
  endtask

  task automatic test_single();
    do_reset();
    req_cmd_in = 4'h1; req_data_in = 32'hA5A5_0001; hold_ready = 1'b0;
    tick();
    vectors++;
    if (hold_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL single_early_valid: got %b expected 0", hold_valid);
    end
    req_cmd_in = '0; req_data_in = 32'h0000_0002;
    tick();
    vectors++;
    if ({hold_valid, hold_prio_req, hold_data1, hold_data2, hold_count} !==
        {1'b1, 4'h1, 32'hA5A5_0001, 32'h0000_0002, 3'd1}) begin
      miscompares++;
      $display("FAIL single_head: got v=%b c=%h d1=%h d2=%h n=%0d expected v=1 c=1 d1=a5a50001 d2=00000002 n=1",
               hold_valid, hold_prio_req, hold_data1, hold_data2, hold_count);
    end
    hold_ready = 1'b1;
    tick();
    hold_ready = 1'b0;
    vectors++;
    if (obs !== '0) begin
      miscompares++;
      $display("FAIL single_drained: got %h expected 0", obs);
    end
    $display("test_single done");
  endtask

  task automatic test_fill_overflow();
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      send_req(4'(i), 32'h1000_0000 | i, 32'h2000_0000 | i, 1'b0, 1'b0);
      vectors++;
      if (obs !== model_out()) begin
        miscompares++;
        $display("FAIL fill_req%0d: got %h expected %h", i, obs, model_out());
      end
      if (i == 4) begin
        vectors++;
        if (hold_full !== 1'b1) begin
          miscompares++;
          $display("FAIL fill_full: got %b expected 1", hold_full);
        end
      end
    end
    vectors++;
    if ({hold_drop, hold_count, hold_prio_req} !== {1'b1, 3'd4, 4'h1}) begin
      miscompares++;
      $display("FAIL overflow_drop: got drop=%b n=%0d head=%h expected drop=1 n=4 head=1",
               hold_drop, hold_count, hold_prio_req);
    end
    tick();
    vectors++;
    if ({hold_drop, hold_drop_cnt} !== {1'b0, STATS ? 8'd1 : 8'd0}) begin
      miscompares++;
      $display("FAIL overflow_pulse: got drop=%b cnt=%0d expected drop=0 cnt=%0d",
               hold_drop, hold_drop_cnt, STATS ? 1 : 0);
    end
    hold_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      vectors++;
      if ({hold_prio_req, hold_data2} !== {4'(k), 32'h2000_0000 | k}) begin
        miscompares++;
        $display("FAIL overflow_order%0d: got c=%h d2=%h expected c=%h d2=%h",
                 k, hold_prio_req, hold_data2, 4'(k), 32'h2000_0000 | k);
      end
      tick();
    end
    hold_ready = 1'b0;
    vectors++;
    if (hold_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL overflow_empty: got %b expected 0", hold_valid);
    end
    $display("test_fill_overflow done");
  endtask

  task automatic test_drain_full();
    do_reset();
    for (int i = 1; i <= 4; i++) send_req(4'(i), 32'(i), 32'(i * 16), 1'b0, 1'b0);
    send_req(4'd5, 32'd5, 32'd80, 1'b0, 1'b1);
    vectors++;
    if ({hold_drop, hold_count, hold_prio_req} !== {1'b0, 3'd4, 4'h2}) begin
      miscompares++;
      $display("FAIL drain_full: got drop=%b n=%0d head=%h expected drop=0 n=4 head=2",
               hold_drop, hold_count, hold_prio_req);
    end
    hold_ready = 1'b1;
    for (int k = 2; k <= 5; k++) begin
      vectors++;
      if ({hold_prio_req, hold_data1, hold_data2} !== {4'(k), 32'(k), 32'(k * 16)}) begin
        miscompares++;
        $display("FAIL drain_order%0d: got c=%h d1=%h d2=%h expected c=%0d", k,
                 hold_prio_req, hold_data1, hold_data2, k);
      end
      tick();
    end
    hold_ready = 1'b0;
    vectors++;
    if (obs !== '0) begin
      miscompares++;
      $display("FAIL drain_empty: got %h expected 0", obs);
    end
    $display("test_drain_full done");
  endtask

  task automatic test_wrap();
    logic [DW-1:0] a, b;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      a = $urandom; b = $urandom;
      send_req(4'(i + 1), a, b, 1'b0, 1'b0);
      vectors++;
      if ({hold_valid, hold_prio_req, hold_data1, hold_data2} !== {1'b1, 4'(i + 1), a, b}) begin
        miscompares++;
        $display("FAIL wrap%0d: got v=%b c=%h d1=%h d2=%h expected v=1 c=%h d1=%h d2=%h",
                 i, hold_valid, hold_prio_req, hold_data1, hold_data2, 4'(i + 1), a, b);
      end
      hold_ready = 1'b1;
      tick();
      hold_ready = 1'b0;
      vectors++;
      if (hold_count !== '0) begin
        miscompares++;
        $display("FAIL wrap%0d_pop: got n=%0d expected 0", i, hold_count);
      end
    end
    $display("test_wrap done");
  endtask

  task automatic test_reset_mid();
    do_reset();
    send_req(4'h3, 32'h33, 32'h333, 1'b0, 1'b0);
    send_req(4'h4, 32'h44, 32'h444, 1'b0, 1'b0);
    req_cmd_in = 4'h9; req_data_in = 32'h99;
    tick();
    reset = 1'b0; req_cmd_in = '0; req_data_in = 32'h999; hold_ready = 1'b1;
    tick();
    vectors++;
    if (obs !== '0) begin
      miscompares++;
      $display("FAIL midreset_clear: got %h expected 0", obs);
    end
    reset = 1'b1; req_data_in = '0; hold_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      vectors++;
      if (obs !== '0) begin
        miscompares++;
        $display("FAIL midreset_no_partial%0d: got %h expected 0", i, obs);
      end
    end
    send_req(4'h7, 32'h77, 32'h777, 1'b0, 1'b0);
    vectors++;
    if ({hold_prio_req, hold_data1, hold_data2, hold_count} !== {4'h7, 32'h77, 32'h777, 3'd1}) begin
      miscompares++;
      $display("FAIL midreset_new: got c=%h d1=%h d2=%h n=%0d expected c=7 d1=77 d2=777 n=1",
               hold_prio_req, hold_data1, hold_data2, hold_count);
    end
    $display("test_reset_mid done");
  endtask

  task automatic test_drop_saturate();
    int pulses = 0;
    do_reset();
    for (int i = 1; i <= 4; i++) send_req(4'(i), 32'(i), 32'(i), 1'b0, 1'b0);
    for (int i = 0; i < 260; i++) begin
      send_req(4'hA, $urandom, $urandom, 1'b0, 1'b0);
      if (hold_drop === 1'b1) pulses++;
    end
    vectors++;
    if (pulses != 260) begin
      miscompares++;
      $display("FAIL sat_pulses: got %0d expected 260", pulses);
    end
    vectors++;
    if ({hold_drop_cnt, hold_count, hold_prio_req} !== {STATS ? 8'd255 : 8'd0, 3'd4, 4'h1}) begin
      miscompares++;
      $display("FAIL sat_count: got cnt=%0d n=%0d head=%h expected cnt=%0d n=4 head=1",
               hold_drop_cnt, hold_count, hold_prio_req, STATS ? 255 : 0);
    end
    $display("test_drop_saturate done");
  endtask

  task automatic test_random();
    int ready_pct;
    do_reset();
    for (int n = 0; n < 800; n++) begin
      ready_pct   = (n < 200) ? 10 : (n < 400) ? 90 : (n < 600) ? 50 : 30;
      reset       = ($urandom_range(79) != 0);
      req_cmd_in  = ($urandom_range(3) == 0) ? 4'h0 : 4'($urandom);
      req_data_in = $urandom;
      hold_ready  = ($urandom_range(99) < ready_pct);
      tick();
      vectors++;
      if (obs !== model_out()) begin
        miscompares++;
        $display("FAIL random_cycle%0d: got %h expected %h", n, obs, model_out());
      end
    end
    reset = 1'b1; req_cmd_in = '0; hold_ready = 1'b0;
    $display("test_random done");
  endtask

  initial begin
    reset = 1'b0; req_cmd_in = '0; req_data_in = '0; hold_ready = 1'b0;
    test_reset();
    test_single();
    test_fill_overflow();
    test_drain_full();
    test_wrap();
    test_reset_mid();
    test_drop_saturate();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
